// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions for the register read/write bridges.
// Response codes and the timeout counter width helper.
package axilite_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    function automatic int axil_tmo_width(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axilite_hold_slot.sv
// One-entry valid/ready capture register.
// Loads on handshake, holds until cleared.
module axilite_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             held_o,
    output logic             held_next_o,
    output logic [WIDTH-1:0] data_o
);

    logic             held_q, held_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        held_d = held_q;
        data_d = data_q;
        if (clear_i) begin
            held_d = 1'b0;
        end
        if (valid_i && !held_q) begin
            held_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_q <= 1'b0;
            data_q <= '0;
        end else begin
            held_q <= held_d;
            data_q <= data_d;
        end
    end

    assign ready_o     = !held_q;
    assign held_o      = held_q;
    assign held_next_o = held_d;
    assign data_o      = data_q;

endmodule

// File: rtl/axilite_reg_wr.sv
// AXI4-Lite write slave issuing single register writes with
// optional wait/ack handshake and a bounded acknowledge timeout.
module axilite_reg_wr
    import axilite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 40,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [STRB_WIDTH-1:0] reg_wr_strb,
    output logic                  reg_wr_en,
    input  logic                  reg_wr_wait,
    input  logic                  reg_wr_ack
);

    localparam int CW = axil_tmo_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);
    localparam int WW = DATA_WIDTH + STRB_WIDTH;

    logic          aw_held, aw_held_d;
    logic          w_held, w_held_d;
    logic [WW-1:0] w_slot;
    logic          complete;
    logic          en_q, en_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          unused_prot;

    assign unused_prot = ^s_axil_awprot;

    axilite_hold_slot #(
        .WIDTH(ADDR_WIDTH)
    ) u_aw_slot (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (s_axil_awvalid),
        .ready_o    (s_axil_awready),
        .data_i     (s_axil_awaddr),
        .clear_i    (complete),
        .held_o     (aw_held),
        .held_next_o(aw_held_d),
        .data_o     (reg_wr_addr)
    );

    axilite_hold_slot #(
        .WIDTH(WW)
    ) u_w_slot (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (s_axil_wvalid),
        .ready_o    (s_axil_wready),
        .data_i     ({s_axil_wdata, s_axil_wstrb}),
        .clear_i    (complete),
        .held_o     (w_held),
        .held_next_o(w_held_d),
        .data_o     (w_slot)
    );

    assign {reg_wr_data, reg_wr_strb} = w_slot;

    assign complete = en_q && (reg_wr_ack || cnt_q == '0);

    // A new write waits until any pending response has been taken.
    always_comb begin
        bvalid_d = complete || (bvalid_q && !s_axil_bready);
        bresp_d  = bresp_q;
        if (complete) begin
            bresp_d = reg_wr_ack ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        end
        en_d  = aw_held_d && w_held_d && !bvalid_d;
        cnt_d = cnt_q;
        if (!en_q) begin
            cnt_d = CNT_LOAD;
        end else if (!reg_wr_wait && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= AXIL_RESP_OKAY;
            cnt_q    <= CNT_LOAD;
        end else begin
            en_q     <= en_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            cnt_q    <= cnt_d;
        end
    end

    assign reg_wr_en     = en_q;
    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;

    // unused_prot is intentionally left unconnected
    logic unused_sink;
    assign unused_sink = unused_prot & aw_held & w_held;

endmodule

// File: tb/tb_axilite_reg_wr.sv
// Directed and randomized self-checking bench for axilite_reg_wr.
// Random phase is scored against a transaction-level queue model.
module tb_axilite_reg_wr;

    localparam int DW = 32;
    localparam int AW = 40;
    localparam int SW = DW / 8;
    localparam int TIMEOUT = 2;
    localparam int NWR = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [SW-1:0] r_strb;
    logic          r_en, r_wait, r_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axilite_reg_wr #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (awaddr),
        .s_axil_awprot (awprot),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata  (wdata),
        .s_axil_wstrb  (wstrb),
        .s_axil_wvalid (wvalid),
        .s_axil_wready (wready),
        .s_axil_bresp  (bresp),
        .s_axil_bvalid (bvalid),
        .s_axil_bready (bready),
        .reg_wr_addr   (r_addr),
        .reg_wr_data   (r_data),
        .reg_wr_strb   (r_strb),
        .reg_wr_en     (r_en),
        .reg_wr_wait   (r_wait),
        .reg_wr_ack    (r_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_aw(input logic [AW-1:0] a);
        awaddr  = a;
        awvalid = 1'b1;
    endtask

    task automatic put_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
    endtask

    // transaction-level model state for the random phase
    logic [AW-1:0] awq[$];
    logic [DW+SW-1:0] wq[$];
    logic [1:0] bq[$];

    initial begin
        int unwaited;
        int sent_aw, sent_w, done, taken, cyc;
        logic aw_hs, w_hs, fin;

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; r_wait = 1'b0; r_ack = 1'b0;
        step();
        step();
        chk("rst_en", 64'(r_en), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd1);
        chk("rst_addr", 64'(r_addr), 64'd0);
        chk("rst_data", 64'(r_data), 64'd0);
        rst = 1'b0;
        step();

        // same-cycle AW/W, ack tied high
        r_ack = 1'b1; bready = 1'b1;
        put_aw(40'h40);
        put_w(32'hDEADBEEF, 4'hF);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_en_c1", 64'(r_en), 64'd1);
        chk("t1_addr", 64'(r_addr), 64'h40);
        chk("t1_data", 64'(r_data), 64'hDEADBEEF);
        chk("t1_strb", 64'(r_strb), 64'hF);
        chk("t1_bvalid_c1", 64'(bvalid), 64'd0);
        step();
        chk("t1_en_c2", 64'(r_en), 64'd0);
        chk("t1_bvalid_c2", 64'(bvalid), 64'd1);
        chk("t1_bresp", 64'(bresp), 64'd0);
        chk("t1_awready_c2", 64'(awready), 64'd1);
        chk("t1_wready_c2", 64'(wready), 64'd1);
        step();
        chk("t1_bvalid_c3", 64'(bvalid), 64'd0);

        // W first, AW three cycles later
        put_w(32'h12345678, 4'h3);
        step();
        wvalid = 1'b0;
        chk("t2_wready", 64'(wready), 64'd0);
        chk("t2_en_c1", 64'(r_en), 64'd0);
        step();
        step();
        put_aw(40'h8);
        chk("t2_en_c3", 64'(r_en), 64'd0);
        step();
        awvalid = 1'b0;
        chk("t2_en_c4", 64'(r_en), 64'd1);
        chk("t2_addr", 64'(r_addr), 64'h8);
        chk("t2_data", 64'(r_data), 64'h12345678);
        chk("t2_strb", 64'(r_strb), 64'h3);
        step();
        chk("t2_bvalid", 64'(bvalid), 64'd1);
        chk("t2_bresp", 64'(bresp), 64'd0);
        step();

        // bready held low while a second write is offered
        bready = 1'b0;
        put_aw(40'h100);
        put_w(32'hA, 4'h1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t3_en_a", 64'(r_en), 64'd1);
        step();
        chk("t3_bvalid_a", 64'(bvalid), 64'd1);
        put_aw(40'h200);
        put_w(32'hB, 4'h2);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t3_awready_busy", 64'(awready), 64'd0);
        chk("t3_wready_busy", 64'(wready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_en_held", 64'(r_en), 64'd0);
            chk("t3_bvalid_hold", 64'(bvalid), 64'd1);
            chk("t3_bresp_hold", 64'(bresp), 64'd0);
            step();
        end
        bready = 1'b1;
        step();
        chk("t3_bvalid_drop", 64'(bvalid), 64'd0);
        chk("t3_en_b", 64'(r_en), 64'd1);
        chk("t3_addr_b", 64'(r_addr), 64'h200);
        chk("t3_data_b", 64'(r_data), 64'hB);
        step();
        chk("t3_bvalid_b", 64'(bvalid), 64'd1);
        step();

        // timeout, ack low
        r_ack = 1'b0;
        put_aw(40'h300);
        put_w(32'hC, 4'hF);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t4_en_c1", 64'(r_en), 64'd1);
        step();
        chk("t4_en_c2", 64'(r_en), 64'd1);
        chk("t4_bvalid_c2", 64'(bvalid), 64'd0);
        step();
        chk("t4_en_c3", 64'(r_en), 64'd0);
        chk("t4_bvalid_c3", 64'(bvalid), 64'd1);
        chk("t4_bresp_c3", 64'(bresp), 64'd2);
        step();

        // timeout stretched by 10 wait cycles
        r_wait = 1'b1;
        put_aw(40'h304);
        put_w(32'hD, 4'hF);
        for (int i = 1; i <= 12; i++) begin
            step();
            awvalid = 1'b0; wvalid = 1'b0;
            if (i == 11) r_wait = 1'b0;
            chk("t4w_en", 64'(r_en), 64'd1);
            chk("t4w_bvalid", 64'(bvalid), 64'd0);
        end
        step();
        chk("t4w_en_done", 64'(r_en), 64'd0);
        chk("t4w_bvalid", 64'(bvalid), 64'd1);
        chk("t4w_bresp", 64'(bresp), 64'd2);
        step();

        // reset mid-write
        put_aw(40'h400);
        put_w(32'hE, 4'hF);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t5_en_pre", 64'(r_en), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_en", 64'(r_en), 64'd0);
        chk("t5_bvalid", 64'(bvalid), 64'd0);
        chk("t5_awready", 64'(awready), 64'd1);
        chk("t5_wready", 64'(wready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_b", 64'(bvalid), 64'd0);
            chk("t5_no_en", 64'(r_en), 64'd0);
        end

        // random back-to-back traffic
        sent_aw = 0; sent_w = 0; done = 0; taken = 0;
        unwaited = 0; cyc = 0;
        while ((taken < NWR || done < NWR) && cyc < 5000) begin
            chk("rnd_bvalid", 64'(bvalid), 64'(bq.size() != 0));
            chk("rnd_awready", 64'(awready), 64'(awq.size() == 0));
            chk("rnd_wready", 64'(wready), 64'(wq.size() == 0));
            chk("rnd_en", 64'(r_en),
                64'(awq.size() != 0 && wq.size() != 0 && bq.size() == 0));
            if (!awvalid && sent_aw < NWR && $urandom_range(1, 0) == 1) begin
                put_aw({8'($urandom), $urandom});
                sent_aw++;
            end
            if (!wvalid && sent_w < NWR && $urandom_range(1, 0) == 1) begin
                put_w($urandom, 4'($urandom));
                sent_w++;
            end
            bready = ($urandom_range(2, 0) != 0);
            r_ack  = ($urandom_range(1, 0) == 1);
            r_wait = ($urandom_range(3, 0) == 0);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            fin = 1'b0;
            if (r_en && awq.size() != 0 && wq.size() != 0) begin
                chk("rnd_addr", 64'(r_addr), 64'(awq[0]));
                chk("rnd_wdat", 64'({r_data, r_strb}), 64'(wq[0]));
                if (r_ack || unwaited >= TIMEOUT - 1) fin = 1'b1;
                else if (!r_wait) unwaited++;
            end
            if (bvalid && bready && bq.size() != 0) begin
                chk("rnd_bresp", 64'(bresp), 64'(bq[0]));
                void'(bq.pop_front());
                taken++;
            end
            if (fin) begin
                bq.push_back(r_ack ? 2'b00 : 2'b10);
                void'(awq.pop_front());
                void'(wq.pop_front());
                unwaited = 0;
                done++;
            end
            if (aw_hs) awq.push_back(awaddr);
            if (w_hs) wq.push_back({wdata, wstrb});
            step();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            cyc++;
        end
        chk("rnd_timeout", 64'(cyc < 5000), 64'd1);
        chk("rnd_done", 64'(done), 64'(NWR));
        chk("rnd_taken", 64'(taken), 64'(NWR));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
